// File: rtl/hba_pkg.sv
// Shared types and elaboration-time helpers for the HBA bus arbiter.
package hba_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int abus_width(input int periph_w, input int reg_w);
        return periph_w + reg_w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: searches upward from last+1, wrapping.
module rr_pick
    import hba_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        cand   = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last) + k) % N;
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                onehot[cand] = 1'b1;
                idx          = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/hba_arbiter.sv
// Round-robin arbiter sharing one HBA slave bus between several masters,
// with a watchdog that reclaims the bus from a slave that never acknowledges.
module hba_arbiter
    import hba_pkg::*;
#(
    parameter int NUM_MASTERS       = 2,
    parameter int DBUS_WIDTH        = 8,
    parameter int PERIPH_ADDR_WIDTH = 4,
    parameter int REG_ADDR_WIDTH    = 8,
    parameter int TIMEOUT           = 255
) (
    input  logic                                                            clk,
    input  logic                                                            reset,
    input  logic [NUM_MASTERS-1:0]                                          m_req,
    input  logic [NUM_MASTERS-1:0]                                          m_rnw,
    input  logic [NUM_MASTERS-1:0]                                          m_select,
    input  logic [NUM_MASTERS*abus_width(PERIPH_ADDR_WIDTH,REG_ADDR_WIDTH)-1:0] m_abus,
    input  logic [NUM_MASTERS*DBUS_WIDTH-1:0]                               m_dbus,
    output logic [NUM_MASTERS-1:0]                                          m_gnt,
    output logic [NUM_MASTERS-1:0]                                          m_xferack,
    output logic                                                            m_timeout,
    output logic                                                            hba_rnw,
    output logic                                                            hba_select,
    output logic [abus_width(PERIPH_ADDR_WIDTH,REG_ADDR_WIDTH)-1:0]         hba_abus,
    output logic [DBUS_WIDTH-1:0]                                           hba_dbus,
    input  logic                                                            hba_xferack
);

    localparam int ABUS_W = abus_width(PERIPH_ADDR_WIDTH, REG_ADDR_WIDTH);
    localparam int IDX_W  = clog2(NUM_MASTERS);
    localparam int WDOG_W = clog2(TIMEOUT + 1);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT - 1);

    arb_state_t             state;
    logic [IDX_W-1:0]       last_idx;
    logic [IDX_W-1:0]       gnt_idx;
    logic [WDOG_W-1:0]      wdog;
    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;

    rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (m_req),
        .last   (last_idx),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // AND-OR mux keyed by the registered one-hot grant; no grant yields an all-zero bus.
    always_comb begin
        hba_rnw    = 1'b0;
        hba_select = 1'b0;
        hba_abus   = '0;
        hba_dbus   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (m_gnt[i]) begin
                hba_rnw    = hba_rnw | m_rnw[i];
                hba_select = hba_select | m_select[i];
                hba_abus   = hba_abus | m_abus[i*ABUS_W +: ABUS_W];
                hba_dbus   = hba_dbus | m_dbus[i*DBUS_WIDTH +: DBUS_WIDTH];
            end
        end
    end

    assign m_xferack = {NUM_MASTERS{hba_xferack}} & m_gnt;

    // A request drop wins over a simultaneous watchdog expiry, so no timeout pulse is raised then.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ARB_IDLE;
            m_gnt     <= '0;
            gnt_idx   <= '0;
            last_idx  <= IDX_W'(NUM_MASTERS - 1);
            wdog      <= '0;
            m_timeout <= 1'b0;
        end else begin
            m_timeout <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    wdog <= '0;
                    if (pick_valid) begin
                        m_gnt    <= pick_onehot;
                        gnt_idx  <= pick_idx;
                        last_idx <= pick_idx;
                        state    <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (!m_req[gnt_idx]) begin
                        m_gnt <= '0;
                        wdog  <= '0;
                        state <= ARB_RELEASE;
                    end else if (hba_select && !hba_xferack) begin
                        if (wdog >= WDOG_LIMIT) begin
                            m_gnt     <= '0;
                            m_timeout <= 1'b1;
                            wdog      <= '0;
                            state     <= ARB_RELEASE;
                        end else begin
                            wdog <= wdog + 1'b1;
                        end
                    end else begin
                        wdog <= '0;
                    end
                end
                ARB_RELEASE: begin
                    m_gnt <= '0;
                    wdog  <= '0;
                    state <= ARB_IDLE;
                end
                default: begin
                    m_gnt <= '0;
                    wdog  <= '0;
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
